// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: memop codes, FSM encoding, widths.
package mem_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   typedef enum logic [3:0] {
      MOP_NONE = 4'd0,
      MOP_LB   = 4'd1,
      MOP_LH   = 4'd2,
      MOP_LW   = 4'd3,
      MOP_LBU  = 4'd4,
      MOP_LHU  = 4'd5,
      MOP_SB   = 4'd6,
      MOP_SH   = 4'd7,
      MOP_SW   = 4'd8
   } memop_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } mem_state_e;

   // Codes 9..15 decode as neither load nor store, i.e. NONE.
   function automatic logic is_load(input logic [3:0] op);
      return (op == MOP_LB) || (op == MOP_LH) || (op == MOP_LW) ||
             (op == MOP_LBU) || (op == MOP_LHU);
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW);
   endfunction

endpackage

// File: rtl/mem_lane.sv
// Little-endian lane logic: store byte-enable/replication and load extract/extend.
module mem_lane
   import mem_pkg::*;
(
   input  logic [3:0]        st_op,
   input  logic [1:0]        st_off,
   input  logic [DATA_W-1:0] sdata,
   output logic [3:0]        st_be,
   output logic [DATA_W-1:0] st_wdata,
   input  logic [3:0]        ld_op,
   input  logic [1:0]        ld_off,
   input  logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] ld_data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      st_be    = 4'b0000;
      st_wdata = '0;
      case (st_op)
         MOP_SB: begin
            st_be    = 4'b0001 << st_off;
            st_wdata = {4{sdata[7:0]}};
         end
         MOP_SH: begin
            st_be    = st_off[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{sdata[15:0]}};
         end
         MOP_SW: begin
            st_be    = 4'b1111;
            st_wdata = sdata;
         end
         default: ;
      endcase
   end

   // Halfwords pick their lane from addr[1] alone; addr[0] is never consulted here.
   always_comb begin
      byte_lane = rdata[7:0];
      case (ld_off)
         2'd1:    byte_lane = rdata[15:8];
         2'd2:    byte_lane = rdata[23:16];
         2'd3:    byte_lane = rdata[31:24];
         default: byte_lane = rdata[7:0];
      endcase
      half_lane = ld_off[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      ld_data = '0;
      case (ld_op)
         MOP_LB:  ld_data = {{24{byte_lane[7]}}, byte_lane};
         MOP_LBU: ld_data = {24'h0, byte_lane};
         MOP_LH:  ld_data = {{16{half_lane[15]}}, half_lane};
         MOP_LHU: ld_data = {16'h0, half_lane};
         MOP_LW:  ld_data = rdata;
         default: ld_data = '0;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: req/ack data-bus transaction, load align/extend, stall request.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | pass-through for NONE ops; launch bus access for ld/st
//   REQ     | bus_req_o held high with stable fields until bus_ack_i
//   DONE    | present captured result; leave once mem_wb not held
module mem_access
   import mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        stall,
   input  logic              wvalid_i,
   input  logic [REG_W-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [3:0]        memop_i,
   input  logic [DATA_W-1:0] maddr_i,
   input  logic [DATA_W-1:0] sdata_i,
   output logic              wvalid_o,
   output logic [REG_W-1:0]  waddr_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic              stallreq_o,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [DATA_W-1:0] bus_addr_o,
   output logic [3:0]        bus_be_o,
   output logic [DATA_W-1:0] bus_wdata_o,
   input  logic [DATA_W-1:0] bus_rdata_i,
   input  logic              bus_ack_i,
   output logic              misalign_o
);

   mem_state_e        state_q, state_d;
   logic              bus_req_q, bus_we_q;
   logic [DATA_W-1:0] bus_addr_q, bus_wdata_q, rdata_q;
   logic [3:0]        bus_be_q;
   logic [3:0]        op_q;
   logic [1:0]        off_q;
   logic [REG_W-1:0]  waddr_q;
   logic              wvalid_q;

   logic              is_mem, misalign, start;
   logic [3:0]        st_be;
   logic [DATA_W-1:0] st_wdata, ld_data;
   logic              unused_stall;

   assign unused_stall = ^{stall[5], stall[3:0]};
   assign is_mem       = is_load(memop_i) || is_store(memop_i);

`ifdef MEM_MISALIGN_TRAP_EN
   always_comb begin
      misalign = 1'b0;
      case (memop_i)
         MOP_LH, MOP_LHU, MOP_SH: misalign = maddr_i[0];
         MOP_LW, MOP_SW:          misalign = |maddr_i[1:0];
         default:                 misalign = 1'b0;
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

   assign start = rst && (state_q == ST_IDLE) && is_mem && !misalign;

   mem_lane u_lane (
      .st_op    (memop_i),
      .st_off   (maddr_i[1:0]),
      .sdata    (sdata_i),
      .st_be    (st_be),
      .st_wdata (st_wdata),
      .ld_op    (op_q),
      .ld_off   (off_q),
      .rdata    (rdata_q),
      .ld_data  (ld_data)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_be_q    <= 4'b0000;
         bus_wdata_q <= '0;
         rdata_q     <= '0;
         op_q        <= MOP_NONE;
         off_q       <= 2'b00;
         waddr_q     <= '0;
         wvalid_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= is_store(memop_i);
            bus_addr_q  <= {maddr_i[31:2], 2'b00};
            bus_be_q    <= st_be;
            bus_wdata_q <= st_wdata;
            op_q        <= memop_i;
            off_q       <= maddr_i[1:0];
            waddr_q     <= waddr_i;
            wvalid_q    <= wvalid_i;
         end
         if ((state_q == ST_REQ) && bus_ack_i) begin
            bus_req_q <= 1'b0;
            rdata_q   <= bus_rdata_i;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start)     state_d = ST_REQ;
         ST_REQ:  if (bus_ack_i) state_d = ST_DONE;
         ST_DONE: if (!stall[4]) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // Result selection; reset forces a bubble regardless of state.
   always_comb begin
      wvalid_o   = 1'b0;
      waddr_o    = waddr_i;
      wdata_o    = '0;
      stallreq_o = 1'b0;
      misalign_o = 1'b0;
      if (rst) begin
         case (state_q)
            ST_IDLE: begin
               if (misalign) begin
                  misalign_o = 1'b1;
               end else if (is_mem) begin
                  stallreq_o = 1'b1;
               end else begin
                  wvalid_o = wvalid_i;
                  wdata_o  = wdata_i;
               end
            end
            ST_REQ: begin
               stallreq_o = 1'b1;
               waddr_o    = waddr_q;
            end
            ST_DONE: begin
               waddr_o = waddr_q;
               if (is_load(op_q)) begin
                  wvalid_o = wvalid_q;
                  wdata_o  = ld_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus_req_o   = bus_req_q;
   assign bus_we_o    = bus_we_q;
   assign bus_addr_o  = bus_addr_q;
   assign bus_be_o    = bus_be_q;
   assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected results queued at issue, popped when DONE appears.
module tb_mem_access;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        wvalid_i;
   logic [4:0]  waddr_i;
   logic [31:0] wdata_i, maddr_i, sdata_i;
   logic [3:0]  memop_i;
   logic        wvalid_o, stallreq_o, bus_req_o, bus_we_o, misalign_o;
   logic [4:0]  waddr_o;
   logic [31:0] wdata_o, bus_addr_o, bus_wdata_o, bus_rdata_i;
   logic [3:0]  bus_be_o;
   logic        bus_ack_i;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        wvalid;
      logic [31:0] wdata;
      logic [4:0]  waddr;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] bwdata;
      logic        chk_bw;
      int          stalls;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   mem_access dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .wvalid_i    (wvalid_i),
      .waddr_i     (waddr_i),
      .wdata_i     (wdata_i),
      .memop_i     (memop_i),
      .maddr_i     (maddr_i),
      .sdata_i     (sdata_i),
      .wvalid_o    (wvalid_o),
      .waddr_o     (waddr_o),
      .wdata_o     (wdata_o),
      .stallreq_o  (stallreq_o),
      .bus_req_o   (bus_req_o),
      .bus_we_o    (bus_we_o),
      .bus_addr_o  (bus_addr_o),
      .bus_be_o    (bus_be_o),
      .bus_wdata_o (bus_wdata_o),
      .bus_rdata_i (bus_rdata_i),
      .bus_ack_i   (bus_ack_i),
      .misalign_o  (misalign_o)
   );

   // Issue one load/store (caller is just after a rising edge, DUT in IDLE) and run it to completion.
   task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] rdata,
                         input int ack_wait, input int hold,
                         input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_be,
                         input logic [31:0] e_bw, input logic chk_bw,
                         input logic e_wv, input logic [31:0] e_wd);
      exp_t e, got;
      int   cyc    = 0;
      int   reqc   = 0;
      int   stalls = 0;
      bit   done   = 0;
      e.wvalid = e_wv;   e.wdata = e_wd;  e.waddr  = 5'd9;
      e.addr   = e_addr; e.we    = e_we;  e.be     = e_be;
      e.bwdata = e_bw;   e.chk_bw = chk_bw; e.stalls = 2 + ack_wait;
      sb.push_back(e);
      memop_i = op; maddr_i = addr; sdata_i = sdata;
      waddr_i = 5'd9; wvalid_i = 1'b1; wdata_i = 32'h5A5A_5A5A; stall = 6'd0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            checks++;
            if (stallreq_o !== 1'b1 || bus_req_o !== 1'b0 || misalign_o !== 1'b0 || wvalid_o !== 1'b0)
               begin errors++; $display("FAIL %s_issue: stallreq=%b bus_req=%b misalign=%b wvalid=%b, required 1 0 0 0",
                                        name, stallreq_o, bus_req_o, misalign_o, wvalid_o); end
         end
         if (stallreq_o) stalls++;
         if (bus_req_o) begin
            checks++;
            if (bus_addr_o !== e.addr || bus_we_o !== e.we)
               begin errors++; $display("FAIL %s_bus: addr=%h we=%b, required %h %b",
                                        name, bus_addr_o, bus_we_o, e.addr, e.we); end
            if (e.chk_bw) begin
               checks++;
               if (bus_be_o !== e.be || bus_wdata_o !== e.bwdata)
                  begin errors++; $display("FAIL %s_lanes: be=%b wdata=%h, required %b %h",
                                           name, bus_be_o, bus_wdata_o, e.be, e.bwdata); end
            end
            bus_ack_i   = (reqc == ack_wait);
            bus_rdata_i = (reqc == ack_wait) ? rdata : 32'h0BAD_0BAD;
            reqc++;
         end else if (cyc > 1 && !stallreq_o) begin
            done        = 1;
            bus_ack_i   = 1'b0;
            bus_rdata_i = 32'h0BAD_0BAD;
            got = sb.pop_front();
            checks++;
            if (wvalid_o !== got.wvalid || wdata_o !== got.wdata || waddr_o !== got.waddr)
               begin errors++; $display("FAIL %s_result: wvalid=%b wdata=%h waddr=%0d, required %b %h %0d",
                                        name, wvalid_o, wdata_o, waddr_o, got.wvalid, got.wdata, got.waddr); end
            checks++;
            if (stalls !== got.stalls)
               begin errors++; $display("FAIL %s_stalls: got %0d cycles, required %0d", name, stalls, got.stalls); end
            for (int h = 0; h < hold; h++) begin
               stall[4] = 1'b1;
               @(negedge clk);
               checks++;
               if (stallreq_o !== 1'b0 || bus_req_o !== 1'b0 || wvalid_o !== got.wvalid || wdata_o !== got.wdata)
                  begin errors++; $display("FAIL %s_hold: stallreq=%b bus_req=%b wvalid=%b wdata=%h, required 0 0 %b %h",
                                           name, stallreq_o, bus_req_o, wvalid_o, wdata_o, got.wvalid, got.wdata); end
            end
            stall[4] = 1'b0;
         end
      end
      if (!done) begin
         errors++;
         $display("FAIL %s_timeout: no DONE after %0d cycles, required completion", name, cyc);
         bus_ack_i = 1'b0;
         if (sb.size() > 0) void'(sb.pop_front());
      end
      @(posedge clk); #1;
      memop_i = MOP_NONE;
   endtask

   // One NONE-op cycle: must pass straight through with no stall and no bus activity.
   task automatic check_idle(input string name, input logic wv, input logic [4:0] wa, input logic [31:0] wd);
      memop_i = MOP_NONE; wvalid_i = wv; waddr_i = wa; wdata_i = wd;
      @(negedge clk);
      checks++;
      if (wvalid_o !== wv || waddr_o !== wa || wdata_o !== wd || stallreq_o !== 1'b0 || bus_req_o !== 1'b0)
         begin errors++; $display("FAIL %s: wvalid=%b waddr=%0d wdata=%h stallreq=%b bus_req=%b, required %b %0d %h 0 0",
                                  name, wvalid_o, waddr_o, wdata_o, stallreq_o, bus_req_o, wv, wa, wd); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; stall = 6'd0; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
      memop_i = MOP_NONE; wvalid_i = 1'b1; waddr_i = 5'd3; wdata_i = 32'h77; maddr_i = 32'h0; sdata_i = 32'h0;
      repeat (2) @(negedge clk);
      checks++;
      if (wvalid_o !== 1'b0 || stallreq_o !== 1'b0 || misalign_o !== 1'b0)
         begin errors++; $display("FAIL reset_outs: wvalid=%b stallreq=%b misalign=%b, required 0 0 0",
                                  wvalid_o, stallreq_o, misalign_o); end
      checks++;
      if (bus_req_o !== 1'b0 || bus_we_o !== 1'b0 || bus_addr_o !== 32'h0 || bus_be_o !== 4'h0 || bus_wdata_o !== 32'h0)
         begin errors++; $display("FAIL reset_bus: req=%b we=%b addr=%h be=%b wdata=%h, required all zero",
                                  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o); end
      memop_i = MOP_LW;
      @(negedge clk);
      checks++;
      if (stallreq_o !== 1'b0 || bus_req_o !== 1'b0)
         begin errors++; $display("FAIL reset_ld: stallreq=%b bus_req=%b, required 0 0", stallreq_o, bus_req_o); end
      @(posedge clk); #1;
      rst = 1'b1; memop_i = MOP_NONE;
   endtask

   task automatic test_none();
      check_idle("none_a", 1'b1, 5'd5, 32'h0000_1234);
      check_idle("none_b", 1'b0, 5'd17, 32'hFFFF_0000);
   endtask

   task automatic test_loads();
      run_op("lb",  MOP_LB,  32'h1003, 32'h0, 32'h80FF_FFFF, 0, 0, 32'h1000, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FF80);
      check_idle("post_lb", 1'b1, 5'd1, 32'hA1A1_0001);
      run_op("lbu", MOP_LBU, 32'h1003, 32'h0, 32'h80FF_FFFF, 0, 0, 32'h1000, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0080);
      run_op("lh",  MOP_LH,  32'h1002, 32'h0, 32'h8001_7FFF, 1, 0, 32'h1000, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_8001);
      run_op("lhu", MOP_LHU, 32'h1000, 32'h0, 32'h8001_F234, 0, 0, 32'h1000, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0000_F234);
      run_op("lb1", MOP_LB,  32'h1001, 32'h0, 32'h1122_3344, 0, 0, 32'h1000, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0033);
      check_idle("post_loads", 1'b1, 5'd2, 32'hA1A1_0002);
   endtask

   task automatic test_stores();
      run_op("sh", MOP_SH, 32'h2002, 32'hABCD_1234, 32'h0, 0, 0, 32'h2000, 1'b1, 4'b1100, 32'h1234_1234, 1'b1, 1'b0, 32'h0);
      run_op("sb", MOP_SB, 32'h2001, 32'h0000_0055, 32'h0, 0, 0, 32'h2000, 1'b1, 4'b0010, 32'h5555_5555, 1'b1, 1'b0, 32'h0);
      run_op("sw", MOP_SW, 32'h2004, 32'hCAFE_F00D, 32'h0, 2, 0, 32'h2004, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0);
      check_idle("post_stores", 1'b1, 5'd3, 32'hA1A1_0003);
   endtask

   task automatic test_slow_ack_hold();
      run_op("lw_slow", MOP_LW, 32'h3008, 32'h0, 32'hDEAD_BEEF, 3, 1, 32'h3008, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      check_idle("post_hold", 1'b1, 5'd4, 32'hA1A1_0004);
   endtask

   task automatic test_back_to_back();
      run_op("b2b_sb",  MOP_SB,  32'h4003, 32'h0000_00E7, 32'h0, 0, 0, 32'h4000, 1'b1, 4'b1000, 32'hE7E7_E7E7, 1'b1, 1'b0, 32'h0);
      run_op("b2b_lhu", MOP_LHU, 32'h4002, 32'h0, 32'hBEEF_0000, 1, 2, 32'h4000, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0000_BEEF);
      check_idle("post_b2b", 1'b1, 5'd6, 32'hA1A1_0006);
   endtask

   task automatic test_reset_in_req();
      int cyc = 0;
      memop_i = MOP_LW; maddr_i = 32'h5000; wvalid_i = 1'b1; waddr_i = 5'd7; wdata_i = 32'h0;
      while (bus_req_o !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
      checks++;
      if (bus_req_o !== 1'b1)
         begin errors++; $display("FAIL rreq_enter: bus_req=%b, required 1", bus_req_o); end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus_req_o !== 1'b0 || wvalid_o !== 1'b0 || stallreq_o !== 1'b0)
         begin errors++; $display("FAIL rreq_reset: bus_req=%b wvalid=%b stallreq=%b, required 0 0 0",
                                  bus_req_o, wvalid_o, stallreq_o); end
      rst = 1'b1; memop_i = MOP_NONE; wvalid_i = 1'b0; wdata_i = 32'h0000_0C0C;
      bus_ack_i = 1'b1; bus_rdata_i = 32'h1357_9BDF;
      @(negedge clk);
      bus_ack_i = 1'b0;
      @(negedge clk);
      checks++;
      if (bus_req_o !== 1'b0 || stallreq_o !== 1'b0 || wvalid_o !== 1'b0 || wdata_o !== 32'h0000_0C0C)
         begin errors++; $display("FAIL rreq_late_ack: bus_req=%b stallreq=%b wvalid=%b wdata=%h, required 0 0 0 00000c0c",
                                  bus_req_o, stallreq_o, wvalid_o, wdata_o); end
      @(posedge clk); #1;
   endtask

   task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
      memop_i = MOP_LW; maddr_i = 32'h1002; wvalid_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'h0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (misalign_o !== 1'b1 || stallreq_o !== 1'b0 || wvalid_o !== 1'b0 || bus_req_o !== 1'b0)
            begin errors++; $display("FAIL misalign_trap: misalign=%b stallreq=%b wvalid=%b bus_req=%b, required 1 0 0 0",
                                     misalign_o, stallreq_o, wvalid_o, bus_req_o); end
      end
      @(posedge clk); #1;
      memop_i = MOP_NONE;
      check_idle("post_trap", 1'b1, 5'd8, 32'hA1A1_0008);
`else
      run_op("lw_mis", MOP_LW, 32'h1002, 32'h0, 32'h1122_3344, 0, 0, 32'h1000, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h1122_3344);
      run_op("lh_odd", MOP_LH, 32'h1003, 32'h0, 32'h9ABC_0001, 0, 0, 32'h1000, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_9ABC);
      check_idle("post_mis", 1'b1, 5'd8, 32'hA1A1_0008);
`endif
   endtask

   initial begin
      test_reset();
      test_none();
      test_loads();
      test_stores();
      test_slow_ack_hold();
      test_back_to_back();
      test_reset_in_req();
      test_misalign();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
